// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between the round-robin arbiter and its requesters.
// Carries both the decoder-side select/disable pair and the decoded grant vector.
interface rr_decode_arbiter_if;
   logic [3:0] req;
   logic       dis;
   logic [1:0] sel;
   logic       dec_dis;
   logic [3:0] gnt_n;
   logic       busy;

   modport master (
      output req,
      output dis,
      input  sel,
      input  dec_dis,
      input  gnt_n,
      input  busy
   );

   modport slave (
      input  req,
      input  dis,
      output sel,
      output dec_dis,
      output gnt_n,
      output busy
   );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Four-way round-robin arbiter with bounded tenure, driving a 2-to-4 active-low
// decoder (select + disable) and the matching registered one-hot grant vector.
module rr_decode_arbiter #(
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rr_decode_arbiter_if.slave   arb
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

   state_e           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       gntN_q, gntN_d;

   logic [3:0]       otherReq;
   logic [3:0]       rotReq;
   logic [1:0]       rotIdx;
   logic [1:0]       offset;
   logic [1:0]       winner;
   logic             anyOther;

   // Candidates exclude the current owner, rotated so bit 0 is the pointer slot.
   always_comb begin
      otherReq = arb.req;
      if (state_q == GRANT) begin
         otherReq[sel_q] = 1'b0;
      end
      rotReq = 4'b0000;
      rotIdx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         rotIdx    = ptr_q + 2'(i);
         rotReq[i] = otherReq[rotIdx];
      end
      anyOther = |rotReq;
      casez (rotReq)
         4'b???1: offset = 2'd0;
         4'b??10: offset = 2'd1;
         4'b?100: offset = 2'd2;
         4'b1000: offset = 2'd3;
         default: offset = 2'd0;
      endcase
      winner = ptr_q + offset;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      gntN_d  = 4'b1111;

      unique case (state_q)
         IDLE: begin
            if (!arb.dis && anyOther) begin
               state_d = GRANT;
               sel_d   = winner;
               ptr_d   = winner + 2'd1;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (arb.dis) begin
               state_d = IDLE;
               sel_d   = 2'd0;
               cnt_d   = '0;
            end else if (!arb.req[sel_q]) begin
               cnt_d = '0;
               if (anyOther) begin
                  sel_d = winner;
                  ptr_d = winner + 2'd1;
               end else begin
                  state_d = IDLE;
                  sel_d   = 2'd0;
               end
            end else if (cnt_q == CNT_LAST) begin
               // A lone owner simply restarts its tenure instead of being preempted.
               cnt_d = '0;
               if (anyOther) begin
                  sel_d = winner;
                  ptr_d = winner + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            sel_d   = 2'd0;
            cnt_d   = '0;
         end
      endcase

      if (state_d == GRANT) begin
         gntN_d = ~(4'b0001 << sel_d);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         sel_q   <= 2'd0;
         cnt_q   <= '0;
         gntN_q  <= 4'b1111;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         gntN_q  <= gntN_d;
      end
   end

   assign arb.sel     = sel_q;
   assign arb.dec_dis = (state_q == IDLE);
   assign arb.busy    = (state_q == GRANT);
   assign arb.gnt_n   = gntN_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Self-checking bench for rr_decode_arbiter: hand-built vector table, corner-case
// sequences and a randomized run against an ownership-level reference model.
module tb_rr_decode_arbiter;

   localparam int HOLD = 8;

   logic clk = 1'b0;
   logic rstN;

   rr_decode_arbiter_if arbIf();

   rr_decode_arbiter #(
      .HOLD_MAX(HOLD),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .rst_n(rstN),
      .arb(arbIf.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the resource, for how many cycles, and where the search starts.
   int mOwner  = -1;
   int mTenure = 0;
   int mPtr    = 0;

   typedef struct {
      logic [3:0] req;
      logic       dis;
      logic [1:0] expSel;
      logic       expDecDis;
      logic [3:0] expGnt;
      logic       expBusy;
   } vec_t;

   vec_t vecs[15];

   function automatic int pick(input logic [3:0] r, input int from, input int exclude);
      for (int i = 0; i < 4; i++) begin
         int idx;
         idx = (from + i) % 4;
         if (r[idx] && idx != exclude) return idx;
      end
      return -1;
   endfunction

   task automatic modelGrant(input int w);
      mOwner  = w;
      mPtr    = (w + 1) % 4;
      mTenure = 1;
   endtask

   task automatic modelEdge(input logic [3:0] r, input logic d);
      int w;
      if (d) begin
         mOwner  = -1;
         mTenure = 0;
      end else if (mOwner < 0) begin
         w = pick(r, mPtr, -1);
         if (w >= 0) modelGrant(w);
      end else if (!r[mOwner]) begin
         w = pick(r, mPtr, mOwner);
         if (w >= 0) modelGrant(w);
         else begin
            mOwner  = -1;
            mTenure = 0;
         end
      end else begin
         w = pick(r, mPtr, mOwner);
         if (mTenure >= HOLD && w >= 0) modelGrant(w);
         else if (mTenure >= HOLD) mTenure = 1;
         else mTenure++;
      end
   endtask

   task automatic modelReset();
      mOwner  = -1;
      mTenure = 0;
      mPtr    = 0;
   endtask

   task automatic checkOutput(input string name, input logic [1:0] s, input logic dd,
                              input logic [3:0] g, input logic b);
      checks++;
      if ({arbIf.sel, arbIf.dec_dis, arbIf.gnt_n, arbIf.busy} !== {s, dd, g, b}) begin
         errors++;
         $display("[TB] FAIL %s: got sel=%b dec_dis=%b gnt_n=%b busy=%b, want sel=%b dec_dis=%b gnt_n=%b busy=%b",
                  name, arbIf.sel, arbIf.dec_dis, arbIf.gnt_n, arbIf.busy, s, dd, g, b);
      end
   endtask

   task automatic checkModel(input string name);
      if (mOwner < 0) checkOutput(name, 2'd0, 1'b1, 4'b1111, 1'b0);
      else checkOutput(name, 2'(mOwner), 1'b0, ~(4'b0001 << mOwner), 1'b1);
   endtask

   // Called at a falling edge: drive, let one rising edge happen, return at the next falling edge.
   task automatic applyStimulus(input logic [3:0] r, input logic d);
      arbIf.req = r;
      arbIf.dis = d;
      @(posedge clk);
      modelEdge(r, d);
      @(negedge clk);
   endtask

   initial begin
      int stays;
      logic [3:0] rndReq;
      logic       rndDis;

      vecs[0]  = '{4'b0100, 1'b0, 2'd2, 1'b0, 4'b1011, 1'b1};
      vecs[1]  = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b1111, 1'b0};
      vecs[2]  = '{4'b0001, 1'b0, 2'd0, 1'b0, 4'b1110, 1'b1};
      vecs[3]  = '{4'b1001, 1'b0, 2'd0, 1'b0, 4'b1110, 1'b1};
      vecs[4]  = '{4'b1001, 1'b0, 2'd0, 1'b0, 4'b1110, 1'b1};
      vecs[5]  = '{4'b1000, 1'b0, 2'd3, 1'b0, 4'b0111, 1'b1};
      vecs[6]  = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b1111, 1'b0};
      vecs[7]  = '{4'b0010, 1'b0, 2'd1, 1'b0, 4'b1101, 1'b1};
      vecs[8]  = '{4'b0010, 1'b1, 2'd0, 1'b1, 4'b1111, 1'b0};
      vecs[9]  = '{4'b0010, 1'b1, 2'd0, 1'b1, 4'b1111, 1'b0};
      vecs[10] = '{4'b0010, 1'b0, 2'd1, 1'b0, 4'b1101, 1'b1};
      vecs[11] = '{4'b0011, 1'b1, 2'd0, 1'b1, 4'b1111, 1'b0};
      vecs[12] = '{4'b0011, 1'b0, 2'd0, 1'b0, 4'b1110, 1'b1};
      vecs[13] = '{4'b0010, 1'b0, 2'd1, 1'b0, 4'b1101, 1'b1};
      vecs[14] = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b1111, 1'b0};

      rstN      = 1'b0;
      arbIf.req = 4'b0000;
      arbIf.dis = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset", 2'd0, 1'b1, 4'b1111, 1'b0);
      rstN = 1'b1;
      modelReset();

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].req, vecs[i].dis);
         checkOutput($sformatf("vec%0d", i), vecs[i].expSel, vecs[i].expDecDis,
                     vecs[i].expGnt, vecs[i].expBusy);
      end

      // Asynchronous reset while owner 2 holds the grant.
      applyStimulus(4'b0100, 1'b0);
      checkOutput("preReset", 2'd2, 1'b0, 4'b1011, 1'b1);
      #2 rstN = 1'b0;
      #1 checkOutput("asyncReset", 2'd0, 1'b1, 4'b1111, 1'b0);
      modelReset();
      @(negedge clk);
      rstN = 1'b1;

      for (int k = 0; k < 4 * HOLD + 1; k++) begin
         int o;
         applyStimulus(4'b1111, 1'b0);
         o = (k / HOLD) % 4;
         checkOutput($sformatf("contend%0d", k), 2'(o), 1'b0, ~(4'b0001 << o), 1'b1);
      end

      applyStimulus(4'b0000, 1'b0);
      checkOutput("contendRelease", 2'd0, 1'b1, 4'b1111, 1'b0);

      for (int k = 0; k < 3 * HOLD + 2; k++) begin
         applyStimulus(4'b0001, 1'b0);
         checkOutput($sformatf("lone%0d", k), 2'd0, 1'b0, 4'b1110, 1'b1);
      end

      // Tenure is at its second cycle here, so six more cycles pass before rotation.
      stays = 0;
      for (int k = 0; k < 20; k++) begin
         applyStimulus(4'b1001, 1'b0);
         if (arbIf.gnt_n != 4'b1110) break;
         stays++;
      end
      checks++;
      if (stays != HOLD - 2) begin
         errors++;
         $display("[TB] FAIL loneRotateDelay: got %0d extra cycles, want %0d", stays, HOLD - 2);
      end
      checkOutput("loneRotate", 2'd3, 1'b0, 4'b0111, 1'b1);

      rndReq = 4'b0000;
      for (int k = 0; k < 500; k++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 4) == 0) rndReq[b] = ~rndReq[b];
         end
         rndDis = ($urandom_range(0, 11) == 0);
         applyStimulus(rndReq, rndDis);
         checkModel($sformatf("rand%0d", k));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
Four-requester round-robin arbiter that sequences our 2-to-4 active-low select decoder so one shared resource is owned by a single requester at a time. It drives the decoder-side signals (2-bit select plus active-high disable) and also the decoded active-low grant vector. This lets downstream logic use either form. Ownership has a bounded tenure, so no requester can starve the others.

Parameters:
HOLD_MAX, 8, maximum consecutive grant cycles for one requester while another requester is waiting; legal range 1..2^CNT_W.
CNT_W, 4, width of the tenure counter.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  4  request lines, active-high, one per requester; level-sensitive, held high for as long as ownership is wanted.
dis  input  1  arbiter disable, active-high; same polarity as the decoder enable (1 = all outputs off).
sel  output  2  index of the current owner; the decoder select input.
dec_dis  output  1  1 = no owner; drives the decoder enable input directly.
gnt_n  output  4  active-low one-hot grant: 1110, 1101, 1011 or 0111 for owners 0..3; 1111 when idle.
busy  output  1  1 while in GRANT.

Behaviour:
- All outputs are registered. No combinational path from req or dis to any output.
- Internal state:
  - FSM: IDLE or GRANT.
  - ptr[1:0]: round-robin priority pointer.
  - cnt[CNT_W-1:0]: tenure counter.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, ptr=0, cnt=0.
  - sel=00, dec_dis=1, gnt_n=1111, busy=0.
- Winner search:
  - Examine req in order ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first set bit wins.
  - On every new grant to winner w, set ptr = w+1 mod 4.
- Output consistency: gnt_n is always the decoder function of (sel, dec_dis).
  - dec_dis=1 gives 1111.
  - Otherwise bit sel is 0 and all other bits are 1.
- IDLE:
  - dis=1 or req=0000: stay in IDLE; outputs hold their idle values.
  - Otherwise, at the edge: enter GRANT, sel=w, dec_dis=0, busy=1, cnt=0.
  - Grant latency is 1 edge: req sampled high at edge k gives gnt_n valid after edge k.
- GRANT, evaluated each edge, in priority order:
  1. dis=1: go to IDLE. Outputs go to idle values; ptr keeps its value; cnt=0. This is an abort with no handover.
  2. req[sel]=0 (owner released): if another req bit is set, hand over directly to the next winner at this edge with no idle bubble, and set cnt=0. Otherwise go to IDLE.
  3. cnt == HOLD_MAX-1 with at least one other req bit set: forced rotation to the next winner (search from ptr), cnt=0.
  4. cnt == HOLD_MAX-1 with no other request: the owner keeps the grant and cnt restarts at 0. A lone requester is never preempted.
  5. Otherwise: cnt increments by 1 and the grant holds.
- Tenure: with competition, one owner holds at most HOLD_MAX consecutive cycles.
- Fairness: with all four requesting continuously, grants visit 0,1,2,3,0,… Every requester is served within 3·HOLD_MAX cycles of asserting req.
- Simultaneous events:
  - dis beats release and rotation.
  - Owner release beats the tenure limit.
  - A requester that drops and re-raises req in the same cycle it loses ownership is treated as a new request and goes behind the rotation order.
- Reset mid-grant: outputs return to idle values asynchronously, and ptr returns to 0.
- Requirements on req: no glitch filtering is applied; req is assumed synchronous to clk.

Test Plan:
1. Reset: assert rst_n=0 mid-grant (owner 2) → immediately gnt_n=1111, dec_dis=1, sel=00, busy=0. After release, req=1111 → first grant goes to 0 (gnt_n=1110).
2. Single request: req=0100 from idle → after 1 edge sel=10, gnt_n=1011, dec_dis=0, busy=1. Drop req → next edge gnt_n=1111, busy=0.
3. Full contention, HOLD_MAX=8: req=1111 held → gnt_n cycles 1110, 1101, 1011, 0111, 1110, exactly 8 cycles each, with no 1111 cycles in between.
4. Handover: req=1001 with owner 0; drop req[0] at cycle 3 → next edge gnt_n=0111, cnt=0. Then drop req[3] → gnt_n=1111.
5. Disable: owner 1 granted; pulse dis=1 for 2 cycles while req stays 0010 → gnt_n=1111 for those cycles. After dis=0, owner 1 is re-granted one edge later (ptr=2, only requester is 1).
6. Lone long request: req=0001 held for 3·HOLD_MAX cycles → gnt_n stays 1110 throughout and cnt wraps at HOLD_MAX-1. Raise req[3] → rotation to 3 occurs exactly when cnt reaches HOLD_MAX-1.
